// File: rtl/spi_v3_components_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_v3_components_spi_master
// Description : SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first. Runs one
//               full-duplex transfer of nbits per accepted request.
//               Host side uses a val/rdy request (send_*) and a val/rdy
//               response (recv_*). miso is sampled directly because this
//               block generates sclk itself.
// Parameters  : nbits    - transfer width in bits (>= 1)
//               CLK_DIV  - sclk half-period in clk cycles (>= 1)
// Ports       : clk, reset (async, active-low)
//               send_val/send_rdy/send_msg  - request handshake + tx data
//               recv_val/recv_rdy/recv_msg  - response handshake + rx data
//               cs (active-low), sclk (idle low), mosi, miso
//               loopback (only with SPI_V3_MASTER_LOOPBACK_EN defined)
// Options     : SPI_V3_MASTER_LOOPBACK_EN - adds the loopback input; when
//               it is 1 at request accept, the registered mosi is sampled
//               instead of miso for the whole transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_v3_components_spi_master #(
    parameter int nbits   = 34,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send_val,
    output logic             send_rdy,
    input  logic [nbits-1:0] send_msg,
    output logic             recv_val,
    input  logic             recv_rdy,
    output logic [nbits-1:0] recv_msg,
    output logic             cs,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
`ifdef SPI_V3_MASTER_LOOPBACK_EN
    ,
    input  logic             loopback
`endif
);

    localparam int c_BITCNT_W = $clog2(nbits + 1);
    localparam int c_DIV_W    = $clog2(CLK_DIV + 1);

    // Every phase lasts CLK_DIV cycles; SETUP lasts one extra cycle so the
    // first mosi bit has more than a full half-period of setup before the
    // first sclk rise.
    localparam logic [c_DIV_W-1:0]    c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0]    c_SETUP_LAST = c_DIV_W'(CLK_DIV);
    localparam logic [c_BITCNT_W-1:0] c_NBITS      = c_BITCNT_W'(nbits);
    localparam logic [c_BITCNT_W-1:0] c_ONE        = c_BITCNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    logic [c_DIV_W-1:0]    r_div;
    logic [c_BITCNT_W-1:0] r_bitcnt;
    logic [nbits-1:0]      r_tx;
    logic [nbits-1:0]      r_rx;
    logic                  r_send_rdy;
    logic                  r_recv_val;
    logic [nbits-1:0]      r_recv_msg;
    logic                  r_cs;
    logic                  r_sclk;
    logic                  r_mosi;

    logic                  w_sample;
    logic [nbits-1:0]      w_rx_next;
    logic [nbits-1:0]      w_tx_next;

`ifdef SPI_V3_MASTER_LOOPBACK_EN
    // Loopback mode is latched at accept so mid-transfer changes are ignored.
    logic r_lb;
    assign w_sample = r_lb ? r_mosi : miso;
`else
    assign w_sample = miso;
`endif

    // rx shifts left with the new bit entering at the LSB; written as a
    // shift/or so it stays legal for nbits == 1.
    assign w_rx_next = (r_rx << 1) | nbits'(w_sample);
    assign w_tx_next = r_tx << 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_bitcnt   <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_send_rdy <= 1'b1;
            r_recv_val <= 1'b0;
            r_recv_msg <= '0;
            r_cs       <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
`ifdef SPI_V3_MASTER_LOOPBACK_EN
            r_lb       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (send_val && r_send_rdy) begin
                        r_state    <= ST_SETUP;
                        r_tx       <= send_msg;
                        r_rx       <= '0;
                        r_bitcnt   <= c_NBITS;
                        r_div      <= '0;
                        r_send_rdy <= 1'b0;
                        r_cs       <= 1'b0;
                        r_mosi     <= send_msg[nbits-1];
`ifdef SPI_V3_MASTER_LOOPBACK_EN
                        r_lb       <= loopback;
`endif
                    end
                end

                ST_SETUP: begin
                    if (r_div == c_SETUP_LAST) begin
                        r_state <= ST_HIGH;
                        r_div   <= '0;
                        r_sclk  <= 1'b1;
                        r_rx    <= w_rx_next;
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end

                ST_HIGH: begin
                    if (r_div == c_DIV_LAST) begin
                        r_state  <= ST_LOW;
                        r_div    <= '0;
                        r_sclk   <= 1'b0;
                        r_bitcnt <= r_bitcnt - c_ONE;
                        // Advance mosi only while bits remain; after the last
                        // bit mosi keeps its value until the next transfer.
                        if (r_bitcnt != c_ONE) begin
                            r_tx   <= w_tx_next;
                            r_mosi <= w_tx_next[nbits-1];
                        end
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end

                ST_LOW: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        // The low half-period after the final bit completes
                        // the last sclk pulse before the HOLD tail.
                        if (r_bitcnt == '0) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_state <= ST_HIGH;
                            r_sclk  <= 1'b1;
                            r_rx    <= w_rx_next;
                        end
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (r_div == c_DIV_LAST) begin
                        r_state    <= ST_DONE;
                        r_div      <= '0;
                        r_cs       <= 1'b1;
                        r_recv_val <= 1'b1;
                        r_recv_msg <= r_rx;
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end

                ST_DONE: begin
                    if (recv_rdy) begin
                        r_state    <= ST_IDLE;
                        r_recv_val <= 1'b0;
                        r_send_rdy <= 1'b1;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_div      <= '0;
                    r_send_rdy <= 1'b1;
                    r_recv_val <= 1'b0;
                    r_cs       <= 1'b1;
                    r_sclk     <= 1'b0;
                end
            endcase
        end
    end

    assign send_rdy = r_send_rdy;
    assign recv_val = r_recv_val;
    assign recv_msg = r_recv_msg;
    assign cs       = r_cs;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_v3_components_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_v3_components_spi_master
// Description : Directed bench for the SPI initiator. Instance A uses
//               nbits=8, CLK_DIV=2 with a mode-0 minion model; instance B
//               uses nbits=1, CLK_DIV=1 with miso tied high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_v3_components_spi_master;

    logic       clk = 1'b0;
    logic       reset;

    logic       send_val_a, send_rdy_a, recv_val_a, recv_rdy_a;
    logic [7:0] send_msg_a, recv_msg_a;
    logic       cs_a, sclk_a, mosi_a, miso_a;

    logic       send_val_b, send_rdy_b, recv_val_b, recv_rdy_b;
    logic [0:0] send_msg_b, recv_msg_b;
    logic       cs_b, sclk_b, mosi_b, miso_b;

`ifdef SPI_V3_MASTER_LOOPBACK_EN
    logic       loopback_a;
    logic       loopback_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_v3_components_spi_master #(.nbits(8), .CLK_DIV(2)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .send_val (send_val_a),
        .send_rdy (send_rdy_a),
        .send_msg (send_msg_a),
        .recv_val (recv_val_a),
        .recv_rdy (recv_rdy_a),
        .recv_msg (recv_msg_a),
        .cs       (cs_a),
        .sclk     (sclk_a),
        .mosi     (mosi_a),
`ifdef SPI_V3_MASTER_LOOPBACK_EN
        .loopback (loopback_a),
`endif
        .miso     (miso_a)
    );

    spi_v3_components_spi_master #(.nbits(1), .CLK_DIV(1)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .send_val (send_val_b),
        .send_rdy (send_rdy_b),
        .send_msg (send_msg_b),
        .recv_val (recv_val_b),
        .recv_rdy (recv_rdy_b),
        .recv_msg (recv_msg_b),
        .cs       (cs_b),
        .sclk     (sclk_b),
        .mosi     (mosi_b),
`ifdef SPI_V3_MASTER_LOOPBACK_EN
        .loopback (loopback_b),
`endif
        .miso     (miso_b)
    );

    // Mode-0 minion: presents the MSB when cs falls, shifts on each sclk fall.
    logic [7:0] minion_next = 8'h00;
    logic [7:0] m_sh        = 8'h00;
    always @(negedge cs_a) begin
        m_sh   = minion_next;
        miso_a = m_sh[7];
    end
    always @(negedge sclk_a) begin
        if (cs_a === 1'b0) begin
            m_sh   = {m_sh[6:0], 1'b0};
            miso_a = m_sh[7];
        end
    end

    // Pin monitors: sclk rises, mosi as seen by the minion, cs falls.
    int         rises_a     = 0;
    int         rises_cs_hi = 0;
    int         cs_falls_a  = 0;
    int         rises_b     = 0;
    logic [7:0] mosi_log    = 8'h00;
    always @(posedge sclk_a) begin
        rises_a++;
        mosi_log = {mosi_log[6:0], mosi_a};
        if (cs_a !== 1'b0) rises_cs_hi++;
    end
    always @(negedge cs_a) cs_falls_a++;
    always @(posedge sclk_b) rises_b++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request on instance A; lat = clk edges from accept to recv_val.
    task automatic run_a(input logic [7:0] msg, input logic [7:0] resp, output int lat);
        minion_next = resp;
        send_msg_a  = msg;
        send_val_a  = 1'b1;
        tick();
        send_val_a  = 1'b0;
        lat = 0;
        while (recv_val_a !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;
        int base;
        int falls0;
        int nresp;
        int gap;
        logic [7:0] resp [2];
        logic [7:0] mlog [2];

        reset      = 1'b0;
        send_val_a = 1'b0; send_msg_a = 8'h00; recv_rdy_a = 1'b0; miso_a = 1'b0;
        send_val_b = 1'b0; send_msg_b = 1'b0;  recv_rdy_b = 1'b1; miso_b = 1'b1;
`ifdef SPI_V3_MASTER_LOOPBACK_EN
        loopback_a = 1'b0;
        loopback_b = 1'b0;
`endif
        repeat (3) tick();

        // 1. reset state and idle hold
        chk("rst_cs", cs_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_send_rdy", send_rdy_a, 1);
        chk("rst_recv_val", recv_val_a, 0);
        chk("rst_recv_msg", recv_msg_a, 0);
        reset = 1'b1;
        bad = 0;
        repeat (50) begin
            tick();
            if ({cs_a, sclk_a, mosi_a, send_rdy_a, recv_val_a} !== 5'b10010) bad++;
        end
        chk("idle_hold_50", bad, 0);

        // 2. single transfer 0xA5 / minion 0x3C
        base = rises_a;
        run_a(8'hA5, 8'h3C, lat);
        chk("a5_latency", lat, 37);
        chk("a5_recv_msg", recv_msg_a, 8'h3C);
        chk("a5_mosi_bits", mosi_log, 8'hA5);
        chk("a5_rises", rises_a - base, 8);
        chk("a5_cs_done", cs_a, 1);

        // 3. response back-pressure
        bad = 0;
        repeat (10) begin
            tick();
            if (recv_val_a !== 1'b1 || recv_msg_a !== 8'h3C || send_rdy_a !== 1'b0 || cs_a !== 1'b1) bad++;
        end
        chk("stall_stable", bad, 0);
        recv_rdy_a = 1'b1;
        tick();
        chk("stall_send_rdy", send_rdy_a, 1);
        chk("stall_recv_val", recv_val_a, 0);

        // 4. back-to-back 0x01 then 0xFF with send_val held
        falls0      = cs_falls_a;
        minion_next = 8'h96;
        send_msg_a  = 8'h01;
        send_val_a  = 1'b1;
        tick();
        send_msg_a  = 8'hFF;
        minion_next = 8'h69;
        nresp = 0;
        gap   = 0;
        resp[0] = 8'h00; resp[1] = 8'h00; mlog[0] = 8'h00; mlog[1] = 8'h00;
        for (int i = 0; i < 300 && nresp < 2; i++) begin
            tick();
            if (recv_val_a === 1'b1) begin
                resp[nresp] = recv_msg_a;
                mlog[nresp] = mosi_log;
                nresp++;
                if (nresp == 2) send_val_a = 1'b0;
            end
            if (nresp == 1 && cs_a === 1'b1) gap++;
        end
        chk("b2b_nresp", nresp, 2);
        chk("b2b_resp0", resp[0], 8'h96);
        chk("b2b_resp1", resp[1], 8'h69);
        chk("b2b_mosi0", mlog[0], 8'h01);
        chk("b2b_mosi1", mlog[1], 8'hFF);
        chk("b2b_cs_windows", cs_falls_a - falls0, 2);
        chk("b2b_cs_gap", gap >= 1, 1);
        tick();

        // 4b. nbits=1, CLK_DIV=1
        send_msg_b = 1'b1;
        send_val_b = 1'b1;
        tick();
        send_val_b = 1'b0;
        lat = 0;
        while (recv_val_b !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk("n1_latency", lat, 5);
        chk("n1_recv_msg", recv_msg_b, 1);
        chk("n1_rises", rises_b, 1);
        tick();
        chk("n1_send_rdy", send_rdy_b, 1);

        // 5. async abort after the 3rd sclk rise
        base        = rises_a;
        minion_next = 8'h3C;
        send_msg_a  = 8'hA5;
        send_val_a  = 1'b1;
        tick();
        send_val_a  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rises_a - base >= 3) break;
            tick();
        end
        chk("abort_rises", rises_a - base, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_cs", cs_a, 1);
        chk("abort_sclk", sclk_a, 0);
        chk("abort_mosi", mosi_a, 0);
        chk("abort_send_rdy", send_rdy_a, 1);
        tick();
        reset = 1'b1;
        bad = 0;
        repeat (5) begin
            tick();
            if (recv_val_a !== 1'b0 || cs_a !== 1'b1) bad++;
        end
        chk("abort_no_resp", bad, 0);
        run_a(8'h5A, 8'hC3, lat);
        chk("post_abort_latency", lat, 37);
        chk("post_abort_recv", recv_msg_a, 8'hC3);
        chk("post_abort_mosi", mosi_log, 8'h5A);
        tick();

`ifdef SPI_V3_MASTER_LOOPBACK_EN
        // 6. loopback, latched at accept
        minion_next = 8'h00;
        loopback_a  = 1'b1;
        send_msg_a  = 8'h5A;
        send_val_a  = 1'b1;
        tick();
        send_val_a  = 1'b0;
        loopback_a  = 1'b0;
        lat = 0;
        while (recv_val_a !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        chk("lb_on_recv", recv_msg_a, 8'h5A);
        tick();
        run_a(8'h5A, 8'h00, lat);
        chk("lb_off_recv", recv_msg_a, 8'h00);
        tick();
`endif

        chk("no_sclk_cs_high", rises_cs_hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
